// File: rtl/entrada_handshake_fpga_if.sv
// Handshake between the IN-path operand producer and the processor's control/stall logic.
// The processor side drives the request and the consume pulse; the producer returns the operand.
interface entrada_handshake_fpga_if #(
    parameter int IMM_WIDTH = 14
);
    logic                 in_req;
    logic                 cons_ack;
    logic                 stall;
    logic [IMM_WIDTH-1:0] dado_in;
    logic                 dado_valido;

    modport master (output in_req, cons_ack, input stall, dado_in, dado_valido);
    modport slave  (input in_req, cons_ack, output stall, dado_in, dado_valido);
endinterface

// File: rtl/entrada_handshake_fpga.sv
// Operator input for the IN instruction: freezes the core, waits for a debounced confirm press
// and returns the zero-extended switch value. Optional wait limit under macro ENTRADA_TIMEOUT_EN.
module entrada_handshake_fpga #(
    parameter int SW_WIDTH        = 8,
    parameter int IMM_WIDTH       = 14,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TIMEOUT_CYCLES  = 100000000
) (
    input  logic                    clock,
    input  logic                    reset,
    entrada_handshake_fpga_if.slave bus,
    input  logic [SW_WIDTH-1:0]     switches,
    input  logic                    botao,
    output logic                    aguardando
`ifdef ENTRADA_TIMEOUT_EN
    ,
    output logic                    timeout_flag
`endif
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 1 || IMM_WIDTH < SW_WIDTH) begin : g_bad_params
        $error("entrada_handshake_fpga: invalid parameter set");
    end

    typedef enum logic [1:0] {
        OCIOSO,
        ESPERA_SOLTO,
        ESPERA_BOTAO,
        ENTREGA
    } estado_t;

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            stable_q, stable_d;
    logic            stable_prev_q, stable_prev_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press;

    estado_t              estado_q, estado_d;
    logic [IMM_WIDTH-1:0] dado_q, dado_d;
    logic                 valido_q, valido_d;

`ifdef ENTRADA_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] espera_cnt_q, espera_cnt_d;
    logic            tflag_q, tflag_d;
    logic            expira;

    assign expira = (espera_cnt_q == TO_LAST);
`endif

    // botao is asynchronous to clock; two flops before anything looks at it
    always_comb begin
        sync1_d = botao;
        sync2_d = sync1_q;
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
        stable_d      = stable_q;
        db_cnt_d      = '0;
        stable_prev_d = stable_q;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = ~stable_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign press = stable_q & ~stable_prev_q;

    always_comb begin
        estado_d = estado_q;
        dado_d   = dado_q;
        valido_d = 1'b0;
`ifdef ENTRADA_TIMEOUT_EN
        tflag_d      = tflag_q;
        espera_cnt_d = espera_cnt_q;
`endif
        unique case (estado_q)
            OCIOSO: begin
                if (bus.in_req) begin
                    // a button already down must be released before it can confirm
                    estado_d = stable_q ? ESPERA_SOLTO : ESPERA_BOTAO;
`ifdef ENTRADA_TIMEOUT_EN
                    espera_cnt_d = '0;
`endif
                end
            end
            ESPERA_SOLTO, ESPERA_BOTAO: begin
`ifdef ENTRADA_TIMEOUT_EN
                espera_cnt_d = espera_cnt_q + 1'b1;
`endif
                if (!bus.in_req) begin
                    estado_d = OCIOSO;
                end else if (estado_q == ESPERA_SOLTO && !stable_q) begin
                    estado_d = ESPERA_BOTAO;
`ifdef ENTRADA_TIMEOUT_EN
                    espera_cnt_d = '0;
`endif
                end else if (estado_q == ESPERA_BOTAO && press) begin
                    dado_d   = IMM_WIDTH'(switches);
                    valido_d = 1'b1;
                    estado_d = ENTREGA;
`ifdef ENTRADA_TIMEOUT_EN
                    tflag_d = 1'b0;
`endif
                end
`ifdef ENTRADA_TIMEOUT_EN
                else if (expira) begin
                    dado_d   = '0;
                    tflag_d  = 1'b1;
                    valido_d = 1'b1;
                    estado_d = ENTREGA;
                end
`endif
            end
            ENTREGA: begin
                if (bus.cons_ack || !bus.in_req) begin
                    estado_d = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            db_cnt_q      <= '0;
            estado_q      <= OCIOSO;
            dado_q        <= '0;
            valido_q      <= 1'b0;
`ifdef ENTRADA_TIMEOUT_EN
            espera_cnt_q  <= '0;
            tflag_q       <= 1'b0;
`endif
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            db_cnt_q      <= db_cnt_d;
            estado_q      <= estado_d;
            dado_q        <= dado_d;
            valido_q      <= valido_d;
`ifdef ENTRADA_TIMEOUT_EN
            espera_cnt_q  <= espera_cnt_d;
            tflag_q       <= tflag_d;
`endif
        end
    end

    // stall follows in_req combinationally so the core freezes in the request cycle itself
    assign bus.stall       = bus.in_req & (estado_q != ENTREGA) & ~reset;
    assign bus.dado_in     = dado_q;
    assign bus.dado_valido = valido_q;
    assign aguardando      = (estado_q == ESPERA_SOLTO) || (estado_q == ESPERA_BOTAO);
`ifdef ENTRADA_TIMEOUT_EN
    assign timeout_flag    = tflag_q;
`endif

endmodule

// File: doc/entrada_handshake_fpga.md
Name: entrada_handshake_fpga

Overview:
- Producer end of the processor's IN path: when the control unit requests input, the block freezes the processor and waits for the operator to set the switches and press a confirm button.
- The confirm button is debounced; the switch value is latched, zero-extended to immediate width and returned with a valid pulse.
- Sits between the raw board pins (switches, button) and the processor's IN-mux operand and stall/congela logic.

Parameters:
- SW_WIDTH, 8, number of board switches.
- IMM_WIDTH, 14, width of returned operand (matches immediate field).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a button level change (min 2).
- TIMEOUT_CYCLES, 100000000, wait limit used only with the optional feature.

Ports:
- clock, input, 1, single system clock; all state on rising edge.
- reset, input, 1, synchronous, active-high.
- in_req, input, 1, level from control unit: IN instruction in progress.
- cons_ack, input, 1, one-cycle pulse: processor consumed dado_in and retired the IN.
- switches, input, SW_WIDTH, raw switch levels (quasi-static).
- botao, input, 1, raw confirm button, active-high, asynchronous and bouncy.
- stall, output, 1, freeze request to PC/clock divider.
- dado_in, output, IMM_WIDTH, latched operand {zeros, switches}.
- dado_valido, output, 1, one-cycle pulse when dado_in is updated.
- aguardando, output, 1, LED: waiting for the operator.

Behaviour:
- Reset (synchronous): state OCIOSO, dado_in=0, dado_valido=0, aguardando=0, stall=0 (forced while reset=1), 2-FF synchronizer=0, debounced level=0, debounce counter=0.
- Synchronizer: botao passes through 2 FFs before the debouncer; switches are sampled directly at capture.
- Debouncer: counter counts cycles where sync!=stable; it clears when they are equal. At count DEBOUNCE_CYCLES-1 the stable level flips and the counter clears. press = stable rising edge (1 cycle).
- States: OCIOSO, ESPERA_SOLTO, ESPERA_BOTAO, ENTREGA.
- OCIOSO: if in_req, go to ESPERA_SOLTO if stable=1 (button already held), else go to ESPERA_BOTAO.
- ESPERA_SOLTO: when stable=0, go to ESPERA_BOTAO. A held button never produces a capture.
- ESPERA_BOTAO: on press, dado_in <= zero-extended switches, go to ENTREGA. dado_valido=1 in the first ENTREGA cycle only.
- ENTREGA: hold dado_in. Go to OCIOSO on cons_ack=1 or in_req=0.
- stall (combinational) = in_req & (state!=ENTREGA) & ~reset. stall asserts in the same cycle in_req rises; it is low throughout ENTREGA.
- aguardando = 1 in ESPERA_SOLTO and ESPERA_BOTAO.
- in_req falls in an ESPERA_* state (abort): go to OCIOSO next edge; dado_in unchanged; no dado_valido.
- press and in_req fall in the same cycle: the abort wins and there is no capture.
- Back-to-back IN (in_req stays high): cons_ack returns to OCIOSO, which re-enters a wait state; a new press is required for each IN.
- Presses while in OCIOSO or ENTREGA are ignored and not queued.
- Latency: press edge on botao to dado_valido = 2 sync + DEBOUNCE_CYCLES + 1 cycles.

Optional Feature:
- Macro ENTRADA_TIMEOUT_EN.
- Defined:
  - Adds output timeout_flag (1 bit, reset 0) and a wait counter. The counter clears on entering ESPERA_SOLTO/ESPERA_BOTAO and increments each cycle in them.
  - At count TIMEOUT_CYCLES-1: dado_in <= 0, timeout_flag <= 1, go to ENTREGA with the normal dado_valido pulse.
  - timeout_flag clears on the next normal capture or on reset.
- Undefined: no counter, no port; the block waits indefinitely.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20):
- Reset: reset=1 for 2 cycles with in_req=1 -> stall=0, dado_in=0, dado_valido=0, aguardando=0.
- Nominal capture: in_req=1, switches=8'hA5, clean press -> stall=1 and aguardando=1 until capture; dado_in=14'h00A5 with dado_valido=1 exactly 7 cycles after the press; stall=0; cons_ack returns the state to OCIOSO.
- Bounce rejection: botao toggles every 2 cycles for 12 cycles, then stays 1 -> exactly one capture, switches sampled after the settle.
- Held button: botao=1 before in_req rises -> no capture until release plus a fresh press; dado_in keeps its old value meanwhile.
- Abort: in_req drops in ESPERA_BOTAO, press in the same cycle -> no dado_valido, stall=0, state OCIOSO.
- Timeout (macro defined): in_req=1 with no press -> after 20 cycles dado_in=0, timeout_flag=1, dado_valido pulse; the next normal capture clears timeout_flag.
